// File: rtl/fsk_frame_modulator.sv
// M-ary FSK frame generator: start symbol, LSB-first data symbols, stop symbols, optional gap.
// Drives one registered tone frequency word per cycle to the downstream DDS.
module fsk_frame_modulator #(
    parameter int DATA_W    = 32,
    parameter int TONE_BITS = 1,
    parameter int FREQ_W    = 32,
    parameter int CNT_W     = 32,
    parameter int STOP_SYMS = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [CNT_W-1:0]                   symbol_dur,
    input  logic [CNT_W-1:0]                   gap_syms,
    input  logic [FREQ_W*(2**TONE_BITS)-1:0]   tone_frq,
    input  logic [DATA_W-1:0]                  s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic [FREQ_W-1:0]                  out_val,
    output logic                               busy,
    output logic                               sym_strobe,
    output logic                               frame_done
);
    localparam int M       = 2**TONE_BITS;
    localparam int NSYM    = DATA_W / TONE_BITS;
    localparam int SYM_MAX = (NSYM > STOP_SYMS) ? NSYM : STOP_SYMS;
    localparam int SYM_W   = (SYM_MAX > 1) ? $clog2(SYM_MAX) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

    state_t              state, nxt_state;
    logic [CNT_W-1:0]    tick, nxt_tick;
    logic [CNT_W-1:0]    gap_cnt, nxt_gap;
    logic [SYM_W-1:0]    sym_cnt, nxt_sym;
    logic [CNT_W-1:0]    dur_q, gap_q;
    logic [DATA_W-1:0]   data_q;
    logic                xfer, tick_wrap;
    logic [TONE_BITS-1:0] tone_idx;
    logic [FREQ_W-1:0]   nxt_out;
    logic                nxt_stb, nxt_done;

    assign s_ready   = (state == S_IDLE);
    assign busy      = ~s_ready;
    assign xfer      = s_valid && s_ready;
    assign tick_wrap = (tick == dur_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tick       <= '0;
            gap_cnt    <= '0;
            sym_cnt    <= '0;
            dur_q      <= '0;
            gap_q      <= '0;
            data_q     <= '0;
            out_val    <= '0;
            sym_strobe <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            tick       <= nxt_tick;
            gap_cnt    <= nxt_gap;
            sym_cnt    <= nxt_sym;
            out_val    <= nxt_out;
            sym_strobe <= nxt_stb;
            frame_done <= nxt_done;
            if (xfer) begin
                data_q <= s_data;
                dur_q  <= (symbol_dur == '0) ? CNT_W'(1) : symbol_dur;
                gap_q  <= gap_syms;
            end
        end
    end

    // Tick wraps at dur-1; only the wrap moves the symbol counter or the state.
    always_comb begin
        nxt_state = state;
        nxt_tick  = tick;
        nxt_sym   = sym_cnt;
        nxt_gap   = gap_cnt;
        if (state == S_IDLE) begin
            if (s_valid) begin
                nxt_state = S_START;
                nxt_tick  = '0;
                nxt_sym   = '0;
                nxt_gap   = '0;
            end
        end else if (!tick_wrap) begin
            nxt_tick = tick + CNT_W'(1);
        end else begin
            nxt_tick = '0;
            case (state)
                S_START: begin
                    nxt_state = S_DATA;
                    nxt_sym   = '0;
                end
                S_DATA: begin
                    if (sym_cnt == SYM_W'(NSYM-1)) begin
                        nxt_state = S_STOP;
                        nxt_sym   = '0;
                    end else begin
                        nxt_sym = sym_cnt + SYM_W'(1);
                    end
                end
                S_STOP: begin
                    if (sym_cnt == SYM_W'(STOP_SYMS-1)) begin
                        nxt_sym   = '0;
                        nxt_gap   = '0;
                        nxt_state = (gap_q == '0) ? S_IDLE : S_GAP;
                    end else begin
                        nxt_sym = sym_cnt + SYM_W'(1);
                    end
                end
                S_GAP: begin
                    // Gap counts whole symbols so gap_syms*dur is never formed.
                    if (gap_cnt == gap_q - CNT_W'(1)) nxt_state = S_IDLE;
                    else                              nxt_gap   = gap_cnt + CNT_W'(1);
                end
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so the register lines up with it.
    always_comb begin
        tone_idx = TONE_BITS'(M-1);
        case (nxt_state)
            S_START: tone_idx = '0;
            S_DATA:  tone_idx = data_q[int'(nxt_sym)*TONE_BITS +: TONE_BITS];
            default: tone_idx = TONE_BITS'(M-1);
        endcase
        nxt_out  = tone_frq[int'(tone_idx)*FREQ_W +: FREQ_W];
        nxt_stb  = (nxt_state == S_START || nxt_state == S_DATA || nxt_state == S_STOP)
                   && (nxt_tick == '0);
        nxt_done = (nxt_state == S_STOP) && (nxt_sym == SYM_W'(STOP_SYMS-1))
                   && (nxt_tick == dur_q - CNT_W'(1));
    end
endmodule

// File: tb/tb_fsk_frame_modulator.sv
// Randomised and directed bench for fsk_frame_modulator against a per-cycle frame model.
module tb_fsk_frame_modulator;
    localparam int DW = 8, TB = 2, M = 4, FW = 16, CW = 16, STOP = 1, NSYM = DW / TB;

    typedef struct packed {
        logic [TB-1:0] idx;
        logic          stb;
        logic          done;
        logic          busy;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [CW-1:0]   symbol_dur = '0;
    logic [CW-1:0]   gap_syms = '0;
    logic [FW*M-1:0] tone_frq = '0;
    logic [DW-1:0]   s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready, busy, sym_strobe, frame_done;
    logic [FW-1:0]   out_val;

    int   checks = 0, failures = 0;
    int   busy_n = 0, stb_n = 0, done_n = 0;
    bit   xfer;
    exp_t q[$];

    always #5 clk = ~clk;

    fsk_frame_modulator #(
        .DATA_W(DW), .TONE_BITS(TB), .FREQ_W(FW), .CNT_W(CW), .STOP_SYMS(STOP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .symbol_dur(symbol_dur), .gap_syms(gap_syms),
        .tone_frq(tone_frq), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .out_val(out_val), .busy(busy), .sym_strobe(sym_strobe), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] tone(input int k);
        return tone_frq[k*FW +: FW];
    endfunction

    // Whole-frame schedule: symbol list expanded to dur cycles each, then the gap.
    task automatic push_frame(input logic [DW-1:0] d, input int dur, input int gap);
        int n;
        int syms[$];
        exp_t e;
        n = (dur == 0) ? 1 : dur;
        syms.push_back(0);
        for (int i = 0; i < NSYM; i++) syms.push_back(int'((d >> (i*TB)) % M));
        for (int i = 0; i < STOP; i++) syms.push_back(M-1);
        for (int s = 0; s < syms.size(); s++)
            for (int c = 0; c < n; c++) begin
                e.idx  = TB'(syms[s]);
                e.stb  = (c == 0);
                e.done = (s == syms.size()-1) && (c == n-1);
                e.busy = 1'b1;
                q.push_back(e);
            end
        for (int c = 0; c < gap*n; c++) begin
            e.idx = TB'(M-1); e.stb = 1'b0; e.done = 1'b0; e.busy = 1'b1;
            q.push_back(e);
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input int dur, input int gap,
                        input bit new_tones);
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) e = q.pop_front();
        else begin
            e.idx = TB'(M-1); e.stb = 1'b0; e.done = 1'b0; e.busy = 1'b0;
        end
        chk("out_val",    64'(out_val),    64'(tone(int'(e.idx))));
        chk("busy",       64'(busy),       64'(e.busy));
        chk("sym_strobe", 64'(sym_strobe), 64'(e.stb));
        chk("frame_done", 64'(frame_done), 64'(e.done));
        chk("s_ready",    64'(s_ready),    64'(!e.busy));
        busy_n += int'(busy); stb_n += int'(sym_strobe); done_n += int'(frame_done);
        if (new_tones) tone_frq = {$urandom, $urandom};
        s_valid    = v;
        s_data     = d;
        symbol_dur = CW'(dur);
        gap_syms   = CW'(gap);
        xfer = v && !e.busy;
        if (xfer) push_frame(d, dur, gap);
    endtask

    task automatic run(input int n, input int dur, input int gap);
        for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), dur, gap, 1'b0);
    endtask

    task automatic clr_counts();
        busy_n = 0; stb_n = 0; done_n = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        tone_frq = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_val", 64'(out_val), 64'h0);
        chk("rst_busy",    64'(busy),    64'h0);
        chk("rst_strobe",  64'(sym_strobe), 64'h0);
        chk("rst_done",    64'(frame_done), 64'h0);
        chk("rst_ready",   64'(s_ready),    64'h1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // 0x1B, dur 3: tones 0,3,2,1,0 then stop 3; 18 busy cycles.
        run(2, 3, 0);
        clr_counts();
        step(1'b1, 8'h1B, 3, 0, 1'b0);
        run(20, 3, 0);
        chk("f1b_busy_cycles", 64'(busy_n), 64'd18);
        chk("f1b_strobes",     64'(stb_n),  64'd6);
        chk("f1b_done",        64'(done_n), 64'd1);

        // Zero duration behaves as one cycle per symbol.
        clr_counts();
        step(1'b1, 8'hFF, 0, 0, 1'b0);
        run(8, 0, 0);
        chk("dur0_busy_cycles", 64'(busy_n), 64'd6);

        // Two words back to back with a 2-symbol gap at dur 5.
        step(1'b1, 8'h3C, 5, 2, 1'b0);
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 8'hC9, 5, 2, 1'b0);
            if (xfer) begin k = i; break; end
        end
        chk("gap_second_accept_cycle", 64'(k), 64'd41);
        run(45, 5, 2);

        // Reset during data symbol 3 abandons the frame.
        step(1'b1, 8'h96, 4, 1, 1'b0);
        run(17, 4, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_val", 64'(out_val), 64'h0);
        chk("mid_rst_busy",    64'(busy),    64'h0);
        chk("mid_rst_ready",   64'(s_ready), 64'h1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(2, 2, 0);
        step(1'b1, 8'h5A, 2, 0, 1'b0);
        run(16, 2, 0);

        // Duration changed mid-frame only affects the next frame.
        clr_counts();
        step(1'b1, 8'hE1, 4, 0, 1'b0);
        run(30, 9, 0);
        chk("dur_keep_busy", 64'(busy_n), 64'd24);
        clr_counts();
        step(1'b1, 8'h2D, 9, 0, 1'b0);
        run(60, 1, 0);
        chk("dur_next_busy", 64'(busy_n), 64'd54);

        // Random traffic with live tone changes; a pending word is held until accepted.
        begin
            bit hv;
            logic [DW-1:0] hd;
            hv = 1'b0;
            hd = '0;
            for (int n = 0; n < 2500; n++) begin
                bit v;
                if (!hv) begin
                    v  = ($urandom_range(0, 2) == 0);
                    hd = DW'($urandom);
                end else v = 1'b1;
                step(v, hd, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                     $urandom_range(0, 19) == 0);
                hv = v && !xfer;
            end
        end
        run(120, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fsk_frame_modulator.md
Name: fsk_frame_modulator

Overview:
Parametrised M-ary FSK frame generator and successor to the free-running binary FSK word generator. It accepts data words over a valid/ready handshake and frames each one as: start symbol, DATA_W/TONE_BITS data symbols sent LSB-first, STOP_SYMS stop symbols, then a programmable inter-frame gap. Every output cycle it drives a tone frequency word to the downstream DDS. It sits between the transmit word source and the DDS phase accumulator.

Parameters:
DATA_W, 32, payload width per frame; must be a multiple of TONE_BITS.
TONE_BITS, 1, bits per symbol; number of tones M = 2**TONE_BITS.
FREQ_W, 32, width of each tone frequency word.
CNT_W, 32, width of the symbol-duration and gap counters.
STOP_SYMS, 1, number of stop symbols per frame (≥1).

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
symbol_dur  in  CNT_W  clock cycles per symbol; latched at frame accept; 0 is treated as 1.
gap_syms  in  CNT_W  idle symbols after the stop symbols; latched at frame accept.
tone_frq  in  FREQ_W*M  flat tone table; tone k is at bits [k*FREQ_W +: FREQ_W]; sampled live every cycle.
s_data  in  DATA_W  word to transmit.
s_valid  in  1  s_data is valid.
s_ready  out  1  block can accept a word; high only in IDLE.
out_val  out  FREQ_W  registered frequency word to the DDS.
busy  out  1  high in START, DATA, STOP and GAP.
sym_strobe  out  1  one-cycle pulse on the first out_val cycle of every start, data and stop symbol.
frame_done  out  1  one-cycle pulse on the last cycle of the last stop symbol.

Behaviour:
- Reset (async assert, sync release): state IDLE; out_val=0; busy=0; sym_strobe=0; frame_done=0; all counters cleared. Reset mid-frame abandons the frame; the latched word is discarded.
- s_ready = (state==IDLE), combinational from state. Transfer occurs on an edge where s_valid && s_ready. s_data, symbol_dur (forced to 1 if 0) and gap_syms are latched on the transfer.
- IDLE: out_val <= tone[M-1] (mark idle) every cycle. On transfer, go to START.
- START: one symbol of tone[0]. The first cycle of START is the cycle after the transfer.
- DATA: NSYM = DATA_W/TONE_BITS symbols. Symbol i uses tone index = data[i*TONE_BITS +: TONE_BITS], i = 0..NSYM-1.
- STOP: STOP_SYMS symbols of tone[M-1].
- GAP: gap_syms*dur cycles with out_val = tone[M-1] and no sym_strobe. If gap_syms=0, go directly from STOP to IDLE.
- Symbol timing: every symbol lasts exactly dur cycles. A tick counter runs 0..dur-1 and wraps on dur-1, which advances the symbol counter or the state. There are no dropped or extra cycles at symbol or state boundaries.
- Frame length: (1+NSYM+STOP_SYMS)*dur cycles, plus gap_syms*dur, plus at least 1 IDLE cycle before the next transfer. s_ready is always high for at least one cycle between frames.
- Tone table changes take effect on the next out_val register update; the mid-symbol change is visible.
- Arithmetic: tick and gap counters are CNT_W wide and compared against the latched dur. Counters never wrap inside a symbol. The gap counts dur-length symbols, so gap_syms*dur is never formed as a product and cannot overflow.
- s_valid held high with s_ready low: the word is held by the source and is not lost.
- s_data changing after a transfer has no effect on the current frame.

Test Plan:
- TONE_BITS=1, DATA_W=8, dur=4, gap=0, tone0=0x100, tone1=0x200, s_data=0xA5 -> out_val sequence 0x100×4, then 1,0,1,0,0,1,0,1 (×4 each), then 0x200×4; frame_done on cycle 40; 10 sym_strobes; s_ready re-asserts on cycle 41.
- TONE_BITS=2, DATA_W=8, dur=3, tones 0x10/0x20/0x30/0x40, s_data=0x1B -> symbols tone0, tone3, tone2, tone1, tone0, tone3(stop); 18 busy cycles.
- symbol_dur=0, s_data=0xFF (binary, 8b) -> every symbol lasts 1 cycle; 10-cycle frame.
- gap_syms=2, dur=5, s_valid held high with two words -> 10 GAP cycles at tone[M-1] with s_ready=0, then 1 IDLE cycle, then the second frame starts; both words are sent intact.
- rst_n pulsed low during data symbol 3 -> out_val=0, busy=0, s_ready=1 immediately; after release out_val=tone[M-1]; the next transfer sends a fresh full frame.
- symbol_dur changed mid-frame from 4 to 9 -> current frame keeps 4-cycle symbols; the next frame uses 9.
